// File: rtl/glip_loopback_pkg.sv
// Shared types and defaults for the loopback board reset sequencer.
// GLIP_RSTSEQ_STATUS_EN (optional) uses LOCK_LOSS_CNT_W for the lock-loss counter.
package glip_loopback_pkg;

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_STABLE    = 3'd1;
  localparam logic [2:0] ST_COM_UP    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_SW_RST    = 3'd4;

  typedef enum logic [2:0] {
    WAIT_LOCK = ST_WAIT_LOCK,
    STABLE    = ST_STABLE,
    COM_UP    = ST_COM_UP,
    RUN       = ST_RUN,
    SW_RST    = ST_SW_RST
  } rst_seq_state_t;

  localparam int DEF_LOCK_STABLE_CYCLES  = 16;
  localparam int DEF_COM_TO_LOGIC_CYCLES = 8;
  localparam int DEF_SW_RST_CYCLES       = 4;

  localparam int LOCK_LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/glip_loopback_rst_seq_if.sv
// Status/control bundle between the reset sequencer and its surroundings.
// GLIP_RSTSEQ_STATUS_EN adds the lock_loss_cnt status signal.
interface glip_loopback_rst_seq_if;

  logic locked;
  logic rst_req;
  logic rst_com;
  logic rst_logic;
  logic ready;
`ifdef GLIP_RSTSEQ_STATUS_EN
  logic [glip_loopback_pkg::LOCK_LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    output locked, rst_req,
    input  rst_com, rst_logic, ready, lock_loss_cnt
  );

  modport slave (
    input  locked, rst_req,
    output rst_com, rst_logic, ready, lock_loss_cnt
  );
`else
  modport master (
    output locked, rst_req,
    input  rst_com, rst_logic, ready
  );

  modport slave (
    input  locked, rst_req,
    output rst_com, rst_logic, ready
  );
`endif

endinterface

// File: rtl/glip_sync2.sv
// Two-flop synchronizer for asynchronous single-bit status inputs.
module glip_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/glip_loopback_rst_seq.sv
// Ordered reset release (com first, then logic) driven by PLL lock and host requests.
// Optional macro GLIP_RSTSEQ_STATUS_EN adds a saturating lock-loss counter.
//
// state     | meaning
// WAIT_LOCK | PLL not (yet) locked, both resets held
// STABLE    | lock seen, waiting for it to stay up
// COM_UP    | communication logic released, user logic held
// RUN       | all resets released, ready
// SW_RST    | host-requested user logic reset pulse
module glip_loopback_rst_seq
  import glip_loopback_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int COM_TO_LOGIC_CYCLES = DEF_COM_TO_LOGIC_CYCLES,
  parameter int SW_RST_CYCLES       = DEF_SW_RST_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  glip_loopback_rst_seq_if.slave   bus
);

  localparam int CNT_W =
    $clog2(max3(LOCK_STABLE_CYCLES, COM_TO_LOGIC_CYCLES, SW_RST_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COM_LAST  = CNT_W'(COM_TO_LOGIC_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);

  logic           locked_s;
  rst_seq_state_t state_q;
  rst_seq_state_t state_d;
  logic [CNT_W-1:0] cnt_q;
  logic           rst_com_q;
  logic           rst_logic_q;
  logic           ready_q;

  glip_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.locked),
    .q   (locked_s)
  );

  // Lock loss overrides every other transition, including host requests.
  always_comb begin
    state_d = state_q;
    if (!locked_s) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: state_d = STABLE;
        STABLE:    if (cnt_q == LOCK_LAST) state_d = COM_UP;
        COM_UP:    if (cnt_q == COM_LAST)  state_d = RUN;
        RUN:       if (bus.rst_req)        state_d = SW_RST;
        SW_RST:    if (cnt_q == SW_LAST)   state_d = RUN;
        default:   state_d = WAIT_LOCK;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      rst_com_q   <= 1'b1;
      rst_logic_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == STABLE || state_q == COM_UP || state_q == SW_RST) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      rst_com_q   <= (state_d == WAIT_LOCK) || (state_d == STABLE);
      rst_logic_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
    end
  end

  assign bus.rst_com   = rst_com_q;
  assign bus.rst_logic = rst_logic_q;
  assign bus.ready     = ready_q;

`ifdef GLIP_RSTSEQ_STATUS_EN
  logic                       locked_s_q;
  logic [LOCK_LOSS_CNT_W-1:0] loss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_s_q <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      locked_s_q <= locked_s;
      if (locked_s_q && !locked_s && (loss_cnt_q != '1)) begin
        loss_cnt_q <= loss_cnt_q + LOCK_LOSS_CNT_W'(1);
      end
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`endif

endmodule
